// File: rtl/cv32e40p_tracer_pkg.sv
// Tracer types: instruction classes, buffered retire record
// and the opcode values used to classify encodings.
package cv32e40p_tracer_pkg;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_BRANCH = 3'd1,
    CLS_JUMP   = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_SYSTEM = 3'd5,
    CLS_FP     = 3'd6,
    CLS_OTHER  = 3'd7
  } trace_class_e;

  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  instr;
    logic [5:0]   rd_addr;
    logic         we;
    logic [31:0]  wdata;
    trace_class_e cls;
    logic         pending;
  } trace_rec_t;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_OP_FP   = 7'b1010011;
  localparam logic [6:0] OPC_FMADD   = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB   = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB  = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD  = 7'b1001111;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] OPC_CUSTOM1 = 7'b0101011;
  localparam logic [6:0] OPC_CUSTOM2 = 7'b1011011;
  localparam logic [6:0] OPC_CUSTOM3 = 7'b1111011;

endpackage

// File: rtl/cv32e40p_trace_classify.sv
// Combinational instruction classifier for the trace
// retire buffer.
module cv32e40p_trace_classify
  import cv32e40p_tracer_pkg::*;
(
  input  logic [31:0]  instr,
  output trace_class_e cls
);

  logic [6:0] op;
  logic [2:0] f3;
  logic       c0_br;
  logic       is_jump;
  logic       is_branch;
  logic       is_load;
  logic       is_store;
  logic       is_sys;
  logic       is_fp;
  logic       is_alu;

  assign op = instr[6:0];
  assign f3 = instr[14:12];

  // custom-0 funct3 11x holds the immediate branches
  assign c0_br = (op == OPC_CUSTOM0) && (f3[2:1] == 2'b11);

  assign is_jump   = (op == OPC_JAL) || (op == OPC_JALR);
  assign is_branch = (op == OPC_BRANCH) || c0_br;
  assign is_load   = (op == OPC_LOAD);
  assign is_store  = (op == OPC_STORE);
  assign is_sys    = (op == OPC_SYSTEM) || (op == OPC_FENCE);
  assign is_fp     = (op == OPC_OP_FP) || (op == OPC_FMADD)
                  || (op == OPC_FMSUB) || (op == OPC_FNMSUB)
                  || (op == OPC_FNMADD);
  assign is_alu    = (op == OPC_OP) || (op == OPC_OPIMM)
                  || (op == OPC_LUI) || (op == OPC_AUIPC)
                  || ((op == OPC_CUSTOM0) && !c0_br)
                  || (op == OPC_CUSTOM1) || (op == OPC_CUSTOM2)
                  || (op == OPC_CUSTOM3);

  always_comb begin
    cls = CLS_OTHER;
    unique case (1'b1)
      is_jump:   cls = CLS_JUMP;
      is_branch: cls = CLS_BRANCH;
      is_load:   cls = CLS_LOAD;
      is_store:  cls = CLS_STORE;
      is_sys:    cls = CLS_SYSTEM;
      is_fp:     cls = CLS_FP;
      is_alu:    cls = CLS_ALU;
      default:   cls = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/cv32e40p_trace_retire_buffer.sv
// In-order retire buffer: holds records until late writebacks
// land, then hands complete records to the tracer.
module cv32e40p_trace_retire_buffer
  import cv32e40p_tracer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ret_valid_i,
  output logic         ret_ready_o,
  input  logic [31:0]  ret_pc_i,
  input  logic [31:0]  ret_instr_i,
  input  logic [5:0]   ret_rd_addr_i,
  input  logic         ret_rd_we_i,
  input  logic         ret_rd_late_i,
  input  logic [31:0]  ret_rd_wdata_i,
  input  logic         late_wb_valid_i,
  input  logic [5:0]   late_wb_addr_i,
  input  logic [31:0]  late_wb_data_i,
  output logic         trc_valid_o,
  input  logic         trc_ready_i,
  output logic [31:0]  trc_pc_o,
  output logic [31:0]  trc_instr_o,
  output logic [5:0]   trc_rd_addr_o,
  output logic         trc_rd_we_o,
  output logic [31:0]  trc_rd_wdata_o,
  output trace_class_e trc_class_o,
  output logic         overflow_o,
  output logic         orphan_wb_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  trace_rec_t      mem [DEPTH];
  trace_rec_t      head;
  trace_rec_t      new_rec;
  trace_class_e    new_cls;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            rd_nz;
  logic            wb_hit;
  logic [PW-1:0]   wb_idx;

  cv32e40p_trace_classify u_classify (
    .instr (ret_instr_i),
    .cls   (new_cls)
  );

  assign ret_ready_o = count < CW'(DEPTH);
  assign push        = ret_valid_i && ret_ready_o;

  assign head        = mem[rd_ptr];
  assign trc_valid_o = (count != '0) && !head.pending;
  assign pop         = trc_valid_o && trc_ready_i;

  assign trc_pc_o       = head.pc;
  assign trc_instr_o    = head.instr;
  assign trc_rd_addr_o  = head.rd_addr;
  assign trc_rd_we_o    = head.we;
  assign trc_rd_wdata_o = head.wdata;
  assign trc_class_o    = head.cls;

  // x0 writes are recorded as no-write; f0 (6'd32) is real
  assign rd_nz = ret_rd_addr_i != 6'd0;

  always_comb begin
    new_rec         = '0;
    new_rec.pc      = ret_pc_i;
    new_rec.instr   = ret_instr_i;
    new_rec.rd_addr = ret_rd_addr_i;
    new_rec.we      = ret_rd_we_i && rd_nz;
    new_rec.wdata   = ret_rd_wdata_i;
    new_rec.cls     = new_cls;
    new_rec.pending = ret_rd_we_i && ret_rd_late_i && rd_nz;
  end

  // Oldest valid pending entry for this register; the slot
  // being pushed this cycle is never part of the search.
  always_comb begin
    wb_hit = 1'b0;
    wb_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx = rd_ptr + PW'(i);
      if (!wb_hit && (CW'(i) < count)
          && mem[idx].pending
          && (mem[idx].rd_addr == late_wb_addr_i)) begin
        wb_hit = 1'b1;
        wb_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      orphan_wb_o <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_rec;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (late_wb_valid_i && wb_hit) begin
        mem[wb_idx].wdata   <= late_wb_data_i;
        mem[wb_idx].pending <= 1'b0;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
      if (ret_valid_i && !ret_ready_o) begin
        overflow_o <= 1'b1;
      end
      if (late_wb_valid_i && !wb_hit) begin
        orphan_wb_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_trace_retire_buffer.sv
// Directed self-checking bench for the trace retire buffer.
module tb_cv32e40p_trace_retire_buffer;
  import cv32e40p_tracer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ret_valid_i;
  logic        ret_ready_o;
  logic [31:0] ret_pc_i;
  logic [31:0] ret_instr_i;
  logic [5:0]  ret_rd_addr_i;
  logic        ret_rd_we_i;
  logic        ret_rd_late_i;
  logic [31:0] ret_rd_wdata_i;
  logic        late_wb_valid_i;
  logic [5:0]  late_wb_addr_i;
  logic [31:0] late_wb_data_i;
  logic        trc_valid_o;
  logic        trc_ready_i;
  logic [31:0] trc_pc_o;
  logic [31:0] trc_instr_o;
  logic [5:0]  trc_rd_addr_o;
  logic        trc_rd_we_o;
  logic [31:0] trc_rd_wdata_o;
  trace_class_e trc_class_o;
  logic        overflow_o;
  logic        orphan_wb_o;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] ADDI  = 32'h00A00293;
  localparam logic [31:0] LW_X6 = 32'h00002303;
  localparam logic [31:0] ADD7  = 32'h000003B3;

  cv32e40p_trace_retire_buffer #(.DEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ret_valid_i     (ret_valid_i),
    .ret_ready_o     (ret_ready_o),
    .ret_pc_i        (ret_pc_i),
    .ret_instr_i     (ret_instr_i),
    .ret_rd_addr_i   (ret_rd_addr_i),
    .ret_rd_we_i     (ret_rd_we_i),
    .ret_rd_late_i   (ret_rd_late_i),
    .ret_rd_wdata_i  (ret_rd_wdata_i),
    .late_wb_valid_i (late_wb_valid_i),
    .late_wb_addr_i  (late_wb_addr_i),
    .late_wb_data_i  (late_wb_data_i),
    .trc_valid_o     (trc_valid_o),
    .trc_ready_i     (trc_ready_i),
    .trc_pc_o        (trc_pc_o),
    .trc_instr_o     (trc_instr_o),
    .trc_rd_addr_o   (trc_rd_addr_o),
    .trc_rd_we_o     (trc_rd_we_o),
    .trc_rd_wdata_o  (trc_rd_wdata_o),
    .trc_class_o     (trc_class_o),
    .overflow_o      (overflow_o),
    .orphan_wb_o     (orphan_wb_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic retire(input logic [31:0] pc,
                        input logic [31:0] instr,
                        input logic [5:0] rd,
                        input logic we,
                        input logic late,
                        input logic [31:0] wd);
    ret_valid_i    = 1'b1;
    ret_pc_i       = pc;
    ret_instr_i    = instr;
    ret_rd_addr_i  = rd;
    ret_rd_we_i    = we;
    ret_rd_late_i  = late;
    ret_rd_wdata_i = wd;
    @(posedge clk);
    #1;
    ret_valid_i   = 1'b0;
    ret_rd_we_i   = 1'b0;
    ret_rd_late_i = 1'b0;
  endtask

  task automatic late_wb(input logic [5:0] rd,
                         input logic [31:0] d);
    late_wb_valid_i = 1'b1;
    late_wb_addr_i  = rd;
    late_wb_data_i  = d;
    @(posedge clk);
    #1;
    late_wb_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks += 4;
    if (trc_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", trc_valid_o);
    end
    if (ret_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", ret_ready_o);
    end
    if (trc_pc_o !== 32'h0 || trc_rd_wdata_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_data pc=%h wd=%h exp=0",
               trc_pc_o, trc_rd_wdata_o);
    end
    if (overflow_o !== 1'b0 || orphan_wb_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags ovf=%b orph=%b exp=0",
               overflow_o, orphan_wb_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu();
    trc_ready_i    = 1'b1;
    ret_valid_i    = 1'b1;
    ret_pc_i       = 32'h80;
    ret_instr_i    = ADDI;
    ret_rd_addr_i  = 6'd5;
    ret_rd_we_i    = 1'b1;
    ret_rd_late_i  = 1'b0;
    ret_rd_wdata_i = 32'hA;
    #1;
    checks++;
    if (trc_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL alu_no_bypass got=%b exp=0", trc_valid_o);
    end
    @(posedge clk);
    #1;
    ret_valid_i = 1'b0;
    ret_rd_we_i = 1'b0;
    checks++;
    if (trc_valid_o !== 1'b1 || trc_pc_o !== 32'h80
        || trc_rd_addr_o !== 6'd5 || trc_rd_wdata_o !== 32'hA
        || trc_rd_we_o !== 1'b1 || trc_class_o !== CLS_ALU
        || trc_instr_o !== ADDI) begin
      failures++;
      $display("FAIL alu_rec v=%b pc=%h rd=%0d wd=%h we=%b cls=%0d exp 1/80/5/a/1/0",
               trc_valid_o, trc_pc_o, trc_rd_addr_o,
               trc_rd_wdata_o, trc_rd_we_o, trc_class_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (trc_valid_o !== 1'b0 || ret_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL alu_empty v=%b rdy=%b exp 0/1",
               trc_valid_o, ret_ready_o);
    end
    trc_ready_i = 1'b0;
  endtask

  task automatic test_late_order();
    trc_ready_i = 1'b0;
    retire(32'h100, LW_X6, 6'd6, 1'b1, 1'b1, 32'h0);
    retire(32'h104, ADD7, 6'd7, 1'b1, 1'b0, 32'h55);
    @(posedge clk);
    #1;
    checks++;
    if (trc_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL late_blocked got=%b exp=0", trc_valid_o);
    end
    late_wb(6'd6, 32'hDEAD);
    checks++;
    if (trc_valid_o !== 1'b1 || trc_pc_o !== 32'h100
        || trc_rd_wdata_o !== 32'hDEAD
        || trc_class_o !== CLS_LOAD || trc_rd_addr_o !== 6'd6) begin
      failures++;
      $display("FAIL late_head v=%b pc=%h wd=%h cls=%0d exp 1/100/dead/3",
               trc_valid_o, trc_pc_o, trc_rd_wdata_o, trc_class_o);
    end
    trc_ready_i = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (trc_valid_o !== 1'b1 || trc_pc_o !== 32'h104
        || trc_rd_wdata_o !== 32'h55 || trc_class_o !== CLS_ALU) begin
      failures++;
      $display("FAIL late_second v=%b pc=%h wd=%h cls=%0d exp 1/104/55/0",
               trc_valid_o, trc_pc_o, trc_rd_wdata_o, trc_class_o);
    end
    @(posedge clk);
    #1;
    trc_ready_i = 1'b0;
    checks++;
    if (trc_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL late_drained got=%b exp=0", trc_valid_o);
    end
  endtask

  task automatic test_two_loads();
    retire(32'h200, LW_X6, 6'd6, 1'b1, 1'b1, 32'h0);
    retire(32'h204, LW_X6, 6'd6, 1'b1, 1'b1, 32'h0);
    late_wb(6'd6, 32'h1);
    checks++;
    if (trc_valid_o !== 1'b1 || trc_pc_o !== 32'h200
        || trc_rd_wdata_o !== 32'h1) begin
      failures++;
      $display("FAIL twold_older v=%b pc=%h wd=%h exp 1/200/1",
               trc_valid_o, trc_pc_o, trc_rd_wdata_o);
    end
    trc_ready_i = 1'b1;
    late_wb(6'd6, 32'h2);
    checks++;
    if (trc_valid_o !== 1'b1 || trc_pc_o !== 32'h204
        || trc_rd_wdata_o !== 32'h2) begin
      failures++;
      $display("FAIL twold_younger v=%b pc=%h wd=%h exp 1/204/2",
               trc_valid_o, trc_pc_o, trc_rd_wdata_o);
    end
    @(posedge clk);
    #1;
    trc_ready_i = 1'b0;
    checks++;
    if (trc_valid_o !== 1'b0 || orphan_wb_o !== 1'b0) begin
      failures++;
      $display("FAIL twold_end v=%b orph=%b exp 0/0",
               trc_valid_o, orphan_wb_o);
    end
  endtask

  task automatic test_overflow();
    int n;
    trc_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      retire(32'h300 + 32'(4 * k), ADDI, 6'd5, 1'b1, 1'b0, 32'(k));
    end
    checks++;
    if (ret_ready_o !== 1'b0 || overflow_o !== 1'b0) begin
      failures++;
      $display("FAIL ovf_full rdy=%b ovf=%b exp 0/0",
               ret_ready_o, overflow_o);
    end
    retire(32'h310, ADDI, 6'd5, 1'b1, 1'b0, 32'h4);
    checks++;
    if (overflow_o !== 1'b1 || ret_ready_o !== 1'b0
        || trc_pc_o !== 32'h300) begin
      failures++;
      $display("FAIL ovf_drop ovf=%b rdy=%b pc=%h exp 1/0/300",
               overflow_o, ret_ready_o, trc_pc_o);
    end
    trc_ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (trc_valid_o) begin
        checks++;
        if (trc_pc_o !== 32'h300 + 32'(4 * n)
            || trc_rd_wdata_o !== 32'(n)) begin
          failures++;
          $display("FAIL ovf_drain_%0d pc=%h wd=%h exp %h/%h",
                   n, trc_pc_o, trc_rd_wdata_o,
                   32'h300 + 32'(4 * n), n);
        end
        n++;
      end
      @(posedge clk);
      #1;
    end
    trc_ready_i = 1'b0;
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL ovf_count got=%0d exp=4", n);
    end
  endtask

  task automatic test_orphan_x0();
    late_wb(6'd9, 32'h1234);
    checks++;
    if (orphan_wb_o !== 1'b1 || trc_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL orphan orph=%b v=%b exp 1/0",
               orphan_wb_o, trc_valid_o);
    end
    retire(32'h400, 32'h00A00013, 6'd0, 1'b1, 1'b1, 32'h77);
    checks++;
    if (trc_valid_o !== 1'b1 || trc_rd_we_o !== 1'b0
        || trc_rd_addr_o !== 6'd0 || trc_pc_o !== 32'h400) begin
      failures++;
      $display("FAIL x0_rec v=%b we=%b rd=%0d pc=%h exp 1/0/0/400",
               trc_valid_o, trc_rd_we_o, trc_rd_addr_o, trc_pc_o);
    end
    trc_ready_i = 1'b1;
    @(posedge clk);
    #1;
    trc_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0]  ins [7];
    trace_class_e exp [7];
    ins[0] = 32'h0000006F; exp[0] = CLS_JUMP;
    ins[1] = 32'h00000063; exp[1] = CLS_BRANCH;
    ins[2] = 32'h00002023; exp[2] = CLS_STORE;
    ins[3] = 32'h00000073; exp[3] = CLS_SYSTEM;
    ins[4] = 32'h00000053; exp[4] = CLS_FP;
    ins[5] = 32'hFFFFFFFF; exp[5] = CLS_OTHER;
    ins[6] = 32'h0000600B; exp[6] = CLS_BRANCH;
    trc_ready_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      retire(32'h500 + 32'(4 * k), ins[k], 6'd1, 1'b1, 1'b0, 32'(k));
      checks++;
      if (trc_valid_o !== 1'b1 || trc_pc_o !== 32'h500 + 32'(4 * k)
          || trc_class_o !== exp[k] || ret_ready_o !== 1'b1) begin
        failures++;
        $display("FAIL b2b_%0d v=%b pc=%h cls=%0d rdy=%b exp cls=%0d",
                 k, trc_valid_o, trc_pc_o, trc_class_o,
                 ret_ready_o, exp[k]);
      end
    end
    @(posedge clk);
    #1;
    trc_ready_i = 1'b0;
    checks++;
    if (trc_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_empty got=%b exp=0", trc_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    trc_ready_i = 1'b0;
    retire(32'h580, ADDI, 6'd5, 1'b1, 1'b0, 32'h1);
    retire(32'h584, ADDI, 6'd5, 1'b1, 1'b0, 32'h2);
    retire(32'h588, LW_X6, 6'd8, 1'b1, 1'b1, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (trc_valid_o !== 1'b0 || ret_ready_o !== 1'b1
        || overflow_o !== 1'b0 || orphan_wb_o !== 1'b0
        || trc_pc_o !== 32'h0) begin
      failures++;
      $display("FAIL rstmid v=%b rdy=%b ovf=%b orph=%b pc=%h exp 0/1/0/0/0",
               trc_valid_o, ret_ready_o, overflow_o,
               orphan_wb_o, trc_pc_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    retire(32'h600, ADDI, 6'd5, 1'b1, 1'b0, 32'h99);
    checks++;
    if (trc_valid_o !== 1'b1 || trc_pc_o !== 32'h600
        || trc_rd_wdata_o !== 32'h99) begin
      failures++;
      $display("FAIL rstmid_after v=%b pc=%h wd=%h exp 1/600/99",
               trc_valid_o, trc_pc_o, trc_rd_wdata_o);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    ret_valid_i     = 1'b0;
    ret_pc_i        = '0;
    ret_instr_i     = '0;
    ret_rd_addr_i   = '0;
    ret_rd_we_i     = 1'b0;
    ret_rd_late_i   = 1'b0;
    ret_rd_wdata_i  = '0;
    late_wb_valid_i = 1'b0;
    late_wb_addr_i  = '0;
    late_wb_data_i  = '0;
    trc_ready_i     = 1'b0;
    test_reset();
    test_alu();
    test_late_order();
    test_two_loads();
    test_overflow();
    test_orphan_x0();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cv32e40p_trace_retire_buffer.md
# cv32e40p_trace_retire_buffer

In-order retire buffer feeding the instruction tracer. It captures each retired instruction record (PC, encoding, destination register) and holds it until any late register writeback (loads, multi-cycle mult/div, FP results) has arrived. It then presents complete records, in program order and tagged with an instruction class, to the tracer over a valid/ready handshake.

## Interface
- DEPTH, 4, number of buffered records; power of two, ≥2
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ret_valid_i  in  1  instruction retires this cycle
- ret_ready_o  out  1  buffer can accept a record (not full)
- ret_pc_i  in  32  PC of retiring instruction
- ret_instr_i  in  32  uncompressed instruction encoding
- ret_rd_addr_i  in  6  destination register; bit 5 set = FP register file
- ret_rd_we_i  in  1  instruction writes a destination register
- ret_rd_late_i  in  1  writeback data arrives later via late_wb_*
- ret_rd_wdata_i  in  32  writeback data when not late
- late_wb_valid_i  in  1  late writeback occurs
- late_wb_addr_i  in  6  late writeback register
- late_wb_data_i  in  32  late writeback data
- trc_valid_o  out  1  head record complete and presented
- trc_ready_i  in  1  tracer consumes head record
- trc_pc_o / trc_instr_o  out  32 / 32  head record fields
- trc_rd_addr_o  out  6  head destination register
- trc_rd_we_o  out  1  head writes a register
- trc_rd_wdata_o  out  32  head writeback data
- trc_class_o  out  3  trace_class_e of head instruction
- overflow_o  out  1  sticky: retire dropped while full
- orphan_wb_o  out  1  sticky: late writeback matched no pending entry

## Operation
- Circular buffer with DEPTH entries; wr_ptr, rd_ptr of $clog2(DEPTH) bits; count of $clog2(DEPTH)+1 bits.
- Push when ret_valid_i && ret_ready_o. Stored fields: pc, instr, rd_addr, we, wdata, class, pending.
- Class is computed at push from ret_instr_i by the classify sub-module.
- pending = ret_rd_we_i && ret_rd_late_i && ret_rd_addr_i != 6'd0.
- Write to x0 (addr 6'd0): stored with we=0 and pending=0. FP f0 (6'd32) is a valid destination.
- Late writeback search covers entries valid at the start of the cycle only. It selects the oldest entry (from rd_ptr) with pending=1 and rd_addr == late_wb_addr_i. It writes wdata and clears pending.
  - No match, including a match only against the same-cycle push: orphan_wb_o set; data discarded.
- ret_valid_i while full: record dropped; overflow_o set; pointers unchanged.
- Head is complete when count≠0 and head pending=0. trc_valid_o = head complete. Pop on trc_valid_o && trc_ready_i.
- Younger complete entries never bypass an incomplete head (strict program order).
- Simultaneous push and pop: count unchanged; both pointers advance.
- ret_ready_o = count < DEPTH. A pop in the same cycle does not free a slot for a push.
- Sticky flags clear only on reset.

## Timing
- Reset: count=0, pointers=0, all entries invalid, overflow_o=0, orphan_wb_o=0.
- During reset: trc_valid_o=0, trc_* data=0, ret_ready_o=1.
- Push in cycle N, not pending: trc_valid_o earliest in N+1 (registered storage, no input-to-output bypass).
- Late writeback in cycle M completing the head: trc_valid_o in M+1, with trc_rd_wdata_o = late data.
- trc_* outputs are driven from the head entry. They are stable while trc_valid_o && !trc_ready_i.
- Pointer wrap-around is modulo DEPTH; count distinguishes full from empty.
- Asynchronous reset mid-operation discards all entries and clears sticky flags immediately.

## Structure
- cv32e40p_tracer_pkg gains:
  - trace_class_e (3 bits): ALU, BRANCH, JUMP, LOAD, STORE, SYSTEM, FP, OTHER
  - trace_rec_t struct: pc, instr, rd_addr, we, wdata, class, pending
- Sub-module cv32e40p_trace_classify: combinational ret_instr_i → trace_class_e, keyed on the package's opcode/instruction masks.
  - JAL/JALR → JUMP
  - BRANCH and custom-0 immediate branches → BRANCH
  - LOAD / STORE opcodes
  - SYSTEM, FENCE → SYSTEM
  - OP_FP and FMADD family → FP
  - Remaining OP/OPIMM/LUI/AUIPC/custom → ALU
  - Anything else → OTHER

## Test plan
- Retire addi x5 (0x00A00293) at PC 0x80, we=1, not late, wdata 0xA, trc_ready_i=1 → next cycle trc_valid_o=1, pc 0x80, rd 5, wdata 0xA, class ALU; buffer empty after.
- Retire lw x6 (late) then add x7 (not late) → trc_valid_o stays 0 until late_wb x6=0xDEAD. Next cycle lw record with 0xDEAD, then add record; order preserved.
- Two pending loads to x6, single late_wb x6=1 → older entry filled. Second late_wb x6=2 → younger filled.
- DEPTH=4, trc_ready_i=0, retire 5 instructions → ret_ready_o=0 after the 4th; 5th dropped, overflow_o=1. Drain yields exactly 4 records.
- late_wb to x9 with no pending entry → orphan_wb_o=1, no output change. Retire with rd=x0, we=1 → record has trc_rd_we_o=0.
- rst_n low with 3 entries buffered, one pending → trc_valid_o=0, ret_ready_o=1, flags 0. After release, a new retire emerges in 1 cycle.
